// File: rtl/ex_stage_mdu_if.sv
// Execute-stage bundle: ID/EX inputs and EX/MA outputs of ex_stage_mdu.
// master drives the instruction side, slave is the execute stage.
interface ex_stage_mdu_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               valid_in;
    logic               stall_in;
    logic               flush_in;
    logic [XLEN-1:0]    pc_in;
    logic [XLEN-1:0]    pc_plus4_in;
    logic [XLEN-1:0]    data_a_in;
    logic [XLEN-1:0]    data_b_in;
    logic [XLEN-1:0]    imm_in;
    logic [XLEN-1:0]    alu_fwd_in;
    logic [XLEN-1:0]    wb_fwd_in;
    logic [1:0]         fwd_sel_a;
    logic [1:0]         fwd_sel_b;
    logic               a_sel_in;
    logic               b_sel_in;
    logic [3:0]         alu_sel_in;
    logic               md_en_in;
    logic [2:0]         funct3_in;
    logic [RADDR_W-1:0] addr_d_in;
    logic               reg_wen_in;
    logic               mem_rw_in;
    logic [1:0]         wb_sel_in;
    logic               busy_out;
    logic [XLEN-1:0]    ex_result;
    logic               valid_out;
    logic               reg_wen_out;
    logic               mem_rw_out;
    logic [1:0]         wb_sel_out;
    logic [2:0]         funct3_out;
    logic [RADDR_W-1:0] addr_d_out;
    logic [XLEN-1:0]    alu_result_out;
    logic [XLEN-1:0]    data_b_out;
    logic [XLEN-1:0]    pc_plus4_out;

    modport master (
        output valid_in, stall_in, flush_in, pc_in, pc_plus4_in,
               data_a_in, data_b_in, imm_in, alu_fwd_in, wb_fwd_in,
               fwd_sel_a, fwd_sel_b, a_sel_in, b_sel_in, alu_sel_in,
               md_en_in, funct3_in, addr_d_in, reg_wen_in, mem_rw_in,
               wb_sel_in,
        input  busy_out, ex_result, valid_out, reg_wen_out, mem_rw_out,
               wb_sel_out, funct3_out, addr_d_out, alu_result_out,
               data_b_out, pc_plus4_out
    );

    modport slave (
        input  valid_in, stall_in, flush_in, pc_in, pc_plus4_in,
               data_a_in, data_b_in, imm_in, alu_fwd_in, wb_fwd_in,
               fwd_sel_a, fwd_sel_b, a_sel_in, b_sel_in, alu_sel_in,
               md_en_in, funct3_in, addr_d_in, reg_wen_in, mem_rw_in,
               wb_sel_in,
        output busy_out, ex_result, valid_out, reg_wen_out, mem_rw_out,
               wb_sel_out, funct3_out, addr_d_out, alu_result_out,
               data_b_out, pc_plus4_out
    );
endinterface

// File: rtl/ex_stage_mdu.sv
// Execute stage: forwarding, ALU, EX/MA register and an optional
// iterative RV32M multiply/divide unit enabled by macro EX_MDU_EN.
module ex_stage_mdu #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input logic          clk,
    input logic          reset,
    ex_stage_mdu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res, res_sel;
    logic [SHW-1:0]  shamt;
    logic            busy;

    always_comb begin
        case (bus.fwd_sel_a)
            2'b01:   fwd_a = bus.alu_fwd_in;
            2'b10:   fwd_a = bus.wb_fwd_in;
            default: fwd_a = bus.data_a_in;
        endcase
        case (bus.fwd_sel_b)
            2'b01:   fwd_b = bus.alu_fwd_in;
            2'b10:   fwd_b = bus.wb_fwd_in;
            default: fwd_b = bus.data_b_in;
        endcase
        op_a = bus.a_sel_in ? bus.pc_in  : fwd_a;
        op_b = bus.b_sel_in ? bus.imm_in : fwd_b;
    end

    always_comb begin
        shamt   = op_b[SHW-1:0];
        alu_res = '0;
        case (bus.alu_sel_in)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}},
                                $signed(op_a) < $signed(op_b)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    assign bus.ex_result = alu_res;

`ifdef EX_MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t            state_q, state_d;
    logic [SHW:0]      cnt_q, cnt_d;
    logic [XLEN-1:0]   mcand_q, mcand_d, dvd_q, dvd_d;
    logic [2*XLEN-1:0] prod_q, prod_d, prod_s;
    logic [2:0]        op_q, op_d, f3;
    logic              neg_q, neg_d, negr_q, negr_d, dz_q, dz_d;
    logic              accept, sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b, q_s, r_s, mdu_res;
    logic [XLEN:0]     sum, shifted, diff;

    assign f3     = bus.funct3_in;
    assign accept = bus.valid_in & bus.md_en_in & ~bus.flush_in & ~reset;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_BUSY;
            S_BUSY:  if (bus.flush_in) state_d = S_IDLE;
                     else if (cnt_q == 1) state_d = S_DONE;
            S_DONE:  if (bus.flush_in || !bus.stall_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_BUSY) || (state_q == S_IDLE && accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            dvd_q   <= '0;
            prod_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            dvd_q   <= dvd_d;
            prod_q  <= prod_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
        end
    end

    // Magnitudes are iterated unsigned; signs are re-applied at the end.
    always_comb begin
        sgn_a   = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
        sgn_b   = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
        a_neg   = sgn_a & fwd_a[XLEN-1];
        b_neg   = sgn_b & fwd_b[XLEN-1];
        abs_a   = a_neg ? -fwd_a : fwd_a;
        abs_b   = b_neg ? -fwd_b : fwd_b;
        sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                  (prod_q[0] ? {1'b0, mcand_q} : '0);
        shifted = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        diff    = shifted - {1'b0, mcand_q};
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        dvd_d   = dvd_q;
        prod_d  = prod_q;
        op_d    = op_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        if (state_q == S_IDLE && accept) begin
            op_d    = f3;
            cnt_d   = (SHW+1)'(XLEN);
            mcand_d = f3[2] ? abs_b : abs_a;
            prod_d  = {{XLEN{1'b0}}, (f3[2] ? abs_a : abs_b)};
            neg_d   = a_neg ^ b_neg;
            negr_d  = a_neg;
            dz_d    = (fwd_b == '0);
            dvd_d   = fwd_a;
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_q - 1'b1;
            if (!op_q[2])
                prod_d = {sum, prod_q[XLEN-1:1]};
            else if (!diff[XLEN])
                prod_d = {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
            else
                prod_d = {shifted[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_s = neg_q ? -prod_q : prod_q;
        q_s    = neg_q  ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        r_s    = negr_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        if (dz_q) begin
            q_s = '1;
            r_s = dvd_q;
        end
        case (op_q)
            3'd0:       mdu_res = prod_s[XLEN-1:0];
            3'd4, 3'd5: mdu_res = q_s;
            3'd6, 3'd7: mdu_res = r_s;
            default:    mdu_res = prod_s[2*XLEN-1:XLEN];
        endcase
        res_sel = (state_q == S_DONE) ? mdu_res : alu_res;
    end
`else
    logic unused_md;
    assign unused_md = bus.md_en_in;
    assign busy      = 1'b0;
    assign res_sel   = alu_res;
`endif

    assign bus.busy_out = busy;

    logic               valid_q, valid_d, reg_wen_q, reg_wen_d;
    logic               mem_rw_q, mem_rw_d;
    logic [1:0]         wb_sel_q, wb_sel_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [RADDR_W-1:0] addr_d_q, addr_d_d;
    logic [XLEN-1:0]    alu_result_q, alu_result_d;
    logic [XLEN-1:0]    data_b_q, data_b_d, pc_plus4_q, pc_plus4_d;

    always_comb begin
        valid_d      = valid_q;
        reg_wen_d    = reg_wen_q;
        mem_rw_d     = mem_rw_q;
        wb_sel_d     = wb_sel_q;
        funct3_d     = funct3_q;
        addr_d_d     = addr_d_q;
        alu_result_d = alu_result_q;
        data_b_d     = data_b_q;
        pc_plus4_d   = pc_plus4_q;
        if (!bus.stall_in) begin
            if (bus.flush_in || !bus.valid_in || busy) begin
                valid_d      = 1'b0;
                reg_wen_d    = 1'b0;
                mem_rw_d     = 1'b0;
                wb_sel_d     = '0;
                funct3_d     = '0;
                addr_d_d     = '0;
                alu_result_d = '0;
                data_b_d     = '0;
                pc_plus4_d   = '0;
            end else begin
                valid_d      = 1'b1;
                reg_wen_d    = bus.reg_wen_in;
                mem_rw_d     = bus.mem_rw_in;
                wb_sel_d     = bus.wb_sel_in;
                funct3_d     = bus.funct3_in;
                addr_d_d     = bus.addr_d_in;
                alu_result_d = res_sel;
                data_b_d     = fwd_b;
                pc_plus4_d   = bus.pc_plus4_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            reg_wen_q    <= 1'b0;
            mem_rw_q     <= 1'b0;
            wb_sel_q     <= '0;
            funct3_q     <= '0;
            addr_d_q     <= '0;
            alu_result_q <= '0;
            data_b_q     <= '0;
            pc_plus4_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_wen_q    <= reg_wen_d;
            mem_rw_q     <= mem_rw_d;
            wb_sel_q     <= wb_sel_d;
            funct3_q     <= funct3_d;
            addr_d_q     <= addr_d_d;
            alu_result_q <= alu_result_d;
            data_b_q     <= data_b_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign bus.valid_out      = valid_q;
    assign bus.reg_wen_out    = reg_wen_q;
    assign bus.mem_rw_out     = mem_rw_q;
    assign bus.wb_sel_out     = wb_sel_q;
    assign bus.funct3_out     = funct3_q;
    assign bus.addr_d_out     = addr_d_q;
    assign bus.alu_result_out = alu_result_q;
    assign bus.data_b_out     = data_b_q;
    assign bus.pc_plus4_out   = pc_plus4_q;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: ALU, EX/MA control and,
// when EX_MDU_EN is defined, the iterative multiply/divide unit.
module tb_ex_stage_mdu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_stage_mdu_if #(.XLEN(32), .RADDR_W(5)) bus ();

    ex_stage_mdu #(.XLEN(32), .RADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.valid_in    = 0; bus.stall_in  = 0; bus.flush_in = 0;
        bus.pc_in       = 0; bus.pc_plus4_in = 0;
        bus.data_a_in   = 0; bus.data_b_in = 0; bus.imm_in   = 0;
        bus.alu_fwd_in  = 0; bus.wb_fwd_in = 0;
        bus.fwd_sel_a   = 0; bus.fwd_sel_b = 0;
        bus.a_sel_in    = 0; bus.b_sel_in  = 0; bus.alu_sel_in = 0;
        bus.md_en_in    = 0; bus.funct3_in = 0; bus.addr_d_in  = 0;
        bus.reg_wen_in  = 0; bus.mem_rw_in = 0; bus.wb_sel_in  = 0;
    endtask

    task automatic alu(input string tag, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        clr();
        bus.valid_in   = 1;
        bus.alu_sel_in = sel;
        bus.data_a_in  = a;
        bus.data_b_in  = b;
        tick();
        chk(tag, bus.alu_result_out, exp);
    endtask

`ifdef EX_MDU_EN
    task automatic mdu_run(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int n;
        clr();
        bus.valid_in   = 1;
        bus.md_en_in   = 1;
        bus.funct3_in  = f3;
        bus.data_a_in  = a;
        bus.data_b_in  = b;
        bus.reg_wen_in = 1;
        #1;
        n = 0;
        while (bus.busy_out && n < 100) begin
            n++;
            tick();
        end
        chk({tag, " busy_cycles"}, n, 33);
        chk({tag, " valid_before"}, {31'b0, bus.valid_out}, 0);
        tick();
        chk({tag, " result"}, bus.alu_result_out, exp);
        chk({tag, " valid_after"}, {31'b0, bus.valid_out}, 1);
        clr();
        #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        clr();
        reset = 1;
        bus.valid_in = 1;
        bus.data_a_in = 32'h55;
        tick();
        tick();
        chk("rst valid", {31'b0, bus.valid_out}, 0);
        chk("rst result", bus.alu_result_out, 0);
        chk("rst busy", {31'b0, bus.busy_out}, 0);
        reset = 0;
        clr();
        tick();

        clr();
        bus.valid_in    = 1;
        bus.data_a_in   = 5;
        bus.fwd_sel_b   = 2'b01;
        bus.alu_fwd_in  = 7;
        bus.data_b_in   = 100;
        bus.addr_d_in   = 5'd3;
        bus.reg_wen_in  = 1;
        bus.wb_sel_in   = 2'd1;
        bus.pc_plus4_in = 32'h104;
        #1;
        chk("add comb", bus.ex_result, 12);
        tick();
        chk("add result", bus.alu_result_out, 12);
        chk("add data_b", bus.data_b_out, 7);
        chk("add valid", {31'b0, bus.valid_out}, 1);
        chk("add addr", {27'b0, bus.addr_d_out}, 3);
        chk("add wen", {31'b0, bus.reg_wen_out}, 1);
        chk("add wbsel", {30'b0, bus.wb_sel_out}, 1);
        chk("add pc4", bus.pc_plus4_out, 32'h104);

        clr();
        bus.valid_in   = 1;
        bus.alu_sel_in = 4'd1;
        bus.fwd_sel_a  = 2'b10;
        bus.wb_fwd_in  = 3;
        bus.b_sel_in   = 1;
        bus.imm_in     = 10;
        tick();
        chk("sub wbfwd imm", bus.alu_result_out, 32'hFFFF_FFF9);

        clr();
        bus.valid_in   = 1;
        bus.alu_sel_in = 4'd0;
        bus.data_a_in  = 1;
        bus.data_b_in  = 1;
        bus.stall_in   = 1;
        tick();
        chk("stall hold", bus.alu_result_out, 32'hFFFF_FFF9);
        bus.stall_in = 0;
        tick();
        chk("stall release", bus.alu_result_out, 2);

        bus.flush_in = 1;
        tick();
        chk("flush valid", {31'b0, bus.valid_out}, 0);
        chk("flush result", bus.alu_result_out, 0);

        alu("slt", 4'd3, 32'hFFFF_FFFF, 1, 1);
        alu("sltu", 4'd4, 32'hFFFF_FFFF, 1, 0);
        alu("sra", 4'd7, 32'h8000_0000, 32'h24, 32'hF800_0000);
        alu("srl", 4'd6, 32'h8000_0000, 32'h24, 32'h0800_0000);
        alu("sll", 4'd2, 1, 32'h21, 2);
        alu("xor", 4'd5, 32'hF0F0, 32'hFF00, 32'h0FF0);
        alu("or", 4'd8, 32'hF0, 32'h0F, 32'hFF);
        alu("and", 4'd9, 32'hF0, 32'h3C, 32'h30);
        alu("pass_b", 4'd10, 32'h11, 32'h55, 32'h55);
        alu("bad op", 4'd11, 32'h11, 32'h55, 0);

        clr();
        bus.valid_in   = 1;
        bus.a_sel_in   = 1;
        bus.pc_in      = 32'h100;
        bus.b_sel_in   = 1;
        bus.imm_in     = 4;
        bus.fwd_sel_a  = 2'b11;
        bus.fwd_sel_b  = 2'b11;
        bus.data_b_in  = 32'h77;
        tick();
        chk("pc+imm", bus.alu_result_out, 32'h104);
        chk("fwd11 data_b", bus.data_b_out, 32'h77);

        bus.valid_in = 0;
        tick();
        chk("invalid bubble", {31'b0, bus.valid_out}, 0);

`ifndef EX_MDU_EN
        clr();
        bus.valid_in  = 1;
        bus.md_en_in  = 1;
        bus.funct3_in = 3'd0;
        bus.data_a_in = 7;
        bus.data_b_in = 32'hFFFF_FFFD;
        #1;
        chk("nomdu busy", {31'b0, bus.busy_out}, 0);
        tick();
        chk("nomdu result", bus.alu_result_out, 4);
        chk("nomdu valid", {31'b0, bus.valid_out}, 1);
`endif

        alu("pre rst add", 4'd0, 1, 1, 2);
        bus.stall_in = 1;
        reset = 1;
        tick();
        chk("rst over stall", bus.alu_result_out, 0);
        chk("rst over stall v", {31'b0, bus.valid_out}, 0);
        reset = 0;
        clr();
        tick();

`ifdef EX_MDU_EN
        mdu_run("mul", 3'd0, 7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        mdu_run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE);
        mdu_run("mulh", 3'd1, 32'h8000_0000, 2, 32'hFFFF_FFFF);
        mdu_run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFF);
        mdu_run("div0", 3'd4, 10, 0, 32'hFFFF_FFFF);
        mdu_run("rem0", 3'd6, 10, 0, 10);
        mdu_run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000);
        mdu_run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        mdu_run("divneg", 3'd4, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
        mdu_run("remneg", 3'd6, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
        mdu_run("divu", 3'd5, 100, 7, 14);

        clr();
        bus.valid_in  = 1;
        bus.md_en_in  = 1;
        bus.funct3_in = 3'd5;
        bus.data_a_in = 100;
        bus.data_b_in = 7;
        tick();
        repeat (9) tick();
        chk("flush pre busy", {31'b0, bus.busy_out}, 1);
        bus.flush_in = 1;
        tick();
        chk("flush busy", {31'b0, bus.busy_out}, 0);
        chk("flush bubble", {31'b0, bus.valid_out}, 0);
        alu("add after flush", 4'd0, 1, 1, 2);
        chk("add after flush v", {31'b0, bus.valid_out}, 1);

        clr();
        bus.valid_in  = 1;
        bus.md_en_in  = 1;
        bus.funct3_in = 3'd7;
        bus.data_a_in = 100;
        bus.data_b_in = 7;
        for (int i = 0; i < 100 && (i < 2 || bus.busy_out); i++) tick();
        chk("remu done busy", {31'b0, bus.busy_out}, 0);
        bus.stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("remu stall result", bus.alu_result_out, 0);
            chk("remu stall busy", {31'b0, bus.busy_out}, 0);
        end
        bus.stall_in = 0;
        tick();
        chk("remu result", bus.alu_result_out, 2);
        chk("remu valid", {31'b0, bus.valid_out}, 1);
        clr();
        tick();

        alu("pre rst mdu", 4'd0, 1, 1, 2);
        clr();
        bus.valid_in  = 1;
        bus.md_en_in  = 1;
        bus.data_a_in = 7;
        bus.data_b_in = 3;
        bus.stall_in  = 1;
        repeat (5) tick();
        chk("mid busy", {31'b0, bus.busy_out}, 1);
        chk("mid stall hold", bus.alu_result_out, 2);
        reset = 1;
        tick();
        chk("rst busy mid", {31'b0, bus.busy_out}, 0);
        chk("rst result mid", bus.alu_result_out, 0);
        chk("rst valid mid", {31'b0, bus.valid_out}, 0);
        reset = 0;
        clr();
        tick();
        chk("post rst busy", {31'b0, bus.busy_out}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
- Parametrised execute stage for the pipelined RV32I/M core.
- Contains:
  - operand forwarding muxes;
  - A/B operand-select muxes;
  - a single-cycle ALU;
  - an iterative multiply/divide unit (MDU, RISC-V M semantics);
  - the EX/MA pipeline register with valid, stall and flush control.
- Sits between the ID/EX register and the memory-access stage.
- Raises busy_out to freeze upstream while an M-op iterates.

Parameters:
- XLEN, 32: datapath width (≥8, even).
- RADDR_W, 5: destination register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  instruction presented.
- stall_in  in  1  downstream stall; EX/MA register holds its value.
- flush_in  in  1  kill current EX instruction.
- pc_in, pc_plus4_in  in  XLEN  PC, PC+4.
- data_a_in, data_b_in  in  XLEN  register file operands.
- imm_in  in  XLEN  immediate.
- alu_fwd_in, wb_fwd_in  in  XLEN  forwarded MA result and WB result.
- fwd_sel_a, fwd_sel_b  in  2  forward selects: 00 reg, 01 alu_fwd, 10 wb_fwd, 11 reg.
- a_sel_in  in  1  ALU A operand: 0 forwarded A, 1 pc_in.
- b_sel_in  in  1  ALU B operand: 0 forwarded B, 1 imm_in.
- alu_sel_in  in  4  ALU op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; others → 0.
- md_en_in  in  1  M-extension op; funct3 selects the operation.
- funct3_in  in  3  funct3.
- addr_d_in  in  RADDR_W  destination register.
- reg_wen_in, mem_rw_in  in  1  control.
- wb_sel_in  in  2  writeback select.
- busy_out  out  1  MDU occupying EX; upstream must hold all inputs.
- ex_result  out  XLEN  combinational ALU result.
- valid_out, reg_wen_out, mem_rw_out  out  1  registered.
- wb_sel_out  out  2  registered.
- funct3_out  out  3  registered.
- addr_d_out  out  RADDR_W  registered.
- alu_result_out, data_b_out, pc_plus4_out  out  XLEN  registered.
  - data_b_out carries the forwarded B operand.

Behaviour:
- Reset: all registered outputs 0; MDU state IDLE; busy_out 0.
- Shift amount = B[log2(XLEN)-1:0]. Arithmetic wraps modulo 2^XLEN.
- EX/MA update rule:
  - stall_in=1: hold all registered outputs, regardless of other inputs.
  - Otherwise, load a bubble (valid/reg_wen/mem_rw/all fields 0) if any of:
    - flush_in=1;
    - valid_in=0;
    - busy_out=1.
  - Otherwise, load the instruction. Latency for ALU ops: 1 cycle.
- MDU FSM (IDLE, BUSY, DONE):
  - IDLE→BUSY: on valid_in & md_en_in & !flush_in. Capture the forwarded operands; counter=XLEN.
  - busy_out is combinational: high in that accept cycle and in every BUSY cycle.
  - BUSY: one shift-add or restoring-divide step per cycle. Counter decrements; at 1 → DONE.
  - DONE: busy_out=0. The result is loaded into alu_result_out when stall_in=0, then → IDLE. If stall_in=1, remain in DONE.
  - The instruction still presented while in DONE is not re-accepted.
  - Total: an M-op is presented for XLEN+2 cycles; the result is registered at the end of the DONE cycle.
- MDU results by funct3:
  - 0 MUL: low XLEN bits.
  - 1 MULH: signed×signed, high bits.
  - 2 MULHSU: signed×unsigned, high bits.
  - 3 MULHU: unsigned×unsigned, high bits.
  - 4 DIV, 5 DIVU: quotient.
  - 6 REM, 7 REMU: remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Boundary conditions:
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder 0.
  - flush_in in BUSY or DONE: → IDLE next cycle, busy_out 0 next cycle, bubble loaded (unless stall_in).
  - reset at any point: IDLE, with outputs as at reset.
  - stall_in during BUSY: iteration continues; EX/MA holds.

Optional Feature:
- EX_MDU_EN defined: MDU and FSM present as described.
- EX_MDU_EN undefined:
  - no MDU logic;
  - busy_out tied 0;
  - md_en_in ignored, so the instruction executes as its alu_sel_in op with 1-cycle latency.

Test Plan:
- ALU ADD: data_a=5, fwd_sel_b=01, alu_fwd=7, b_sel=0 → alu_result_out=12 next cycle; data_b_out=7.
- MUL: A=7, B=−3 (0xFFFFFFFD), funct3=0, held → busy_out high 33 cycles; alu_result_out=0xFFFFFFEB at cycle 34; valid_out=1 only then.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 10/0 → 0xFFFFFFFF. REM 10/0 → 10. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0.
- DIVU 100/7 started, flush_in at BUSY cycle 10 → busy_out 0 next cycle; bubble loaded; a following ADD 1+1 yields 2 one cycle later.
- stall_in=1 for 3 cycles during DONE of REMU 100/7 → outputs held; after release alu_result_out=2.
- Synchronous reset asserted mid-BUSY → all outputs 0; busy_out 0 next edge.
